// File: rtl/div_job_sequencer_if.sv
// Stream and divider handshake bundle for div_job_sequencer.
// master is the sequencer side; slave is the job source / divider / consumer side.
interface div_job_sequencer_if #(parameter int DATA_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_dividend;
  logic [DATA_W-1:0] in_divisor;
  logic              div_start;
  logic [DATA_W-1:0] div_a;
  logic [DATA_W-1:0] div_b;
  logic              div_busy;
  logic              div_valid;
  logic [DATA_W-1:0] div_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_q;
  logic [1:0]        out_status;

  modport master (
    input  in_valid, in_dividend, in_divisor, div_busy, div_valid, div_q, out_ready,
    output in_ready, div_start, div_a, div_b, out_valid, out_q, out_status
  );
  modport slave (
    output in_valid, in_dividend, in_divisor, div_busy, div_valid, div_q, out_ready,
    input  in_ready, div_start, div_a, div_b, out_valid, out_q, out_status
  );
endinterface

// File: rtl/div_job_sequencer.sv
// Buffers divide jobs in a small FIFO and runs them one at a time through the
// iterative divider, reporting quotient plus OK/DVZ/OVF/TIMEOUT status.
module div_job_sequencer #(
  parameter int DATA_W      = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  div_job_sequencer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] ST_OK = 2'b00, ST_DVZ = 2'b01, ST_OVF = 2'b10, ST_TMO = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
  } job_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, RUN, DRAIN, RESP} state_t;

  job_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  job_t          head;

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{dividend: bus.in_dividend, divisor: bus.in_divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  state_t            state, state_d;
  logic [TW-1:0]     cnt, cnt_d;
  logic              tmo;
  logic              start_d, ov_d;
  logic [DATA_W-1:0] a_d, b_d, q_d;
  logic [1:0]        st_d;

  assign tmo = (cnt == TW'(TIMEOUT_CYC));

  // State and every visible output are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.div_start  <= 1'b0;
      bus.div_a      <= '0;
      bus.div_b      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_q      <= '0;
      bus.out_status <= ST_OK;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      bus.div_start  <= start_d;
      bus.div_a      <= a_d;
      bus.div_b      <= b_d;
      bus.out_valid  <= ov_d;
      bus.out_q      <= q_d;
      bus.out_status <= st_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (!empty) state_d = (head.divisor == '0) ? RESP : ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (bus.div_busy) state_d = RUN;
                else if (tmo)     state_d = RESP;
      RUN:      if (bus.div_valid)                state_d = DRAIN;
                else if (!bus.div_busy || tmo)    state_d = RESP;
      DRAIN:    if (!bus.div_busy || tmo) state_d = RESP;
      RESP:     if (bus.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counter only advances while below TIMEOUT_CYC, so it saturates there.
  always_comb begin
    pop     = 1'b0;
    start_d = 1'b0;
    cnt_d   = cnt;
    a_d     = bus.div_a;
    b_d     = bus.div_b;
    ov_d    = bus.out_valid;
    q_d     = bus.out_q;
    st_d    = bus.out_status;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        a_d = head.dividend;
        b_d = head.divisor;
        if (head.divisor == '0) begin
          q_d  = '0;
          st_d = ST_DVZ;
          ov_d = 1'b1;
        end else begin
          start_d = 1'b1;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT_ACK:
        if (bus.div_busy) cnt_d = '0;
        else if (tmo) begin
          q_d  = '0;
          st_d = ST_TMO;
          ov_d = 1'b1;
        end else cnt_d = cnt + TW'(1);
      RUN:
        if (bus.div_valid) begin
          q_d   = bus.div_q;
          st_d  = ST_OK;
          cnt_d = '0;
        end else if (!bus.div_busy) begin
          q_d  = '0;
          st_d = ST_OVF;
          ov_d = 1'b1;
        end else if (tmo) begin
          q_d  = '0;
          st_d = ST_TMO;
          ov_d = 1'b1;
        end else cnt_d = cnt + TW'(1);
      // A stuck busy still releases the OK result; the next job will time out.
      DRAIN:
        if (!bus.div_busy || tmo) ov_d = 1'b1;
        else cnt_d = cnt + TW'(1);
      RESP: if (bus.out_ready) ov_d = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_div_job_sequencer.sv
// Directed plus randomized bench for div_job_sequencer with a behavioural
// divider model and a result scoreboard.
module tb_div_job_sequencer;
  localparam int DW = 10, DEPTH = 4, TMO = 64;
  localparam int M_OK = 0, M_OVF = 1, M_HANG = 2;

  typedef struct {int mode; int lat; int extra;} djob_t;
  typedef struct {logic [DW-1:0] q; logic [1:0] st;} res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_job_sequencer_if #(.DATA_W(DW)) bus();
  div_job_sequencer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0, n_errors = 0;
  int cyc = 0, n_start = 0, n_resp = 0, last_start_cyc = 0;
  int ph = 0, mc = 0, ml = 0, mx = 0;
  int p_mode = 0, p_lat = 3, p_extra = 0;
  logic [DW-1:0] qa = '0, qb = '0, prev_q = '0;
  logic [1:0] prev_st = '0;
  bit job_live = 0, prev_hold = 0, rnd_done = 0;
  res_t  exp_q[$];
  djob_t job_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic res_t expect_of(input int a, input int b, input int mode);
    res_t r;
    r.q  = '0;
    r.st = 2'b11;
    if (b == 0)              r.st = 2'b01;
    else if (mode == M_OK)   begin r.q = DW'(a / b); r.st = 2'b00; end
    else if (mode == M_OVF)  r.st = 2'b10;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Environment: acceptance recording, divider model, result scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      job_q.delete();
      bus.div_busy  <= 1'b0;
      bus.div_valid <= 1'b0;
      bus.div_q     <= '0;
      ph            <= 0;
      job_live      <= 1'b0;
      prev_hold     <= 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(expect_of(int'(bus.in_dividend), int'(bus.in_divisor), p_mode));
        if (bus.in_divisor != '0) job_q.push_back('{p_mode, p_lat, p_extra});
      end
      bus.div_valid <= 1'b0;
      if (bus.div_start) begin
        n_start        <= n_start + 1;
        last_start_cyc <= cyc;
        job_live       <= 1'b1;
        chk("start_while_busy", (ph != 0) | bus.div_busy | bus.out_valid, 0);
        chk("start_divisor_nz", bus.div_b != '0, 1);
        chk("start_expected", job_q.size() != 0, 1);
        qa <= bus.div_a;
        qb <= bus.div_b;
        mc <= 0;
        if (job_q.size() != 0) begin
          ml <= job_q[0].lat;
          mx <= job_q[0].extra;
          if (job_q[0].mode == M_OK)       begin ph <= 1; bus.div_busy <= 1'b1; end
          else if (job_q[0].mode == M_OVF) begin ph <= 3; bus.div_busy <= 1'b1; end
          else ph <= 0;
          job_q.delete(0);
        end
      end else begin
        case (ph)
          1: begin
            mc <= mc + 1;
            if (mc + 1 == ml) begin
              bus.div_valid <= 1'b1;
              bus.div_q     <= (qb == '0) ? '0 : qa / qb;
              if (mx == 0) begin bus.div_busy <= 1'b0; ph <= 0; end
              else begin ph <= 2; mc <= 0; end
            end
          end
          2: begin
            mc <= mc + 1;
            if (mc + 1 == mx) begin bus.div_busy <= 1'b0; ph <= 0; end
          end
          3: begin
            mc <= mc + 1;
            if (mc + 1 == ml) begin bus.div_busy <= 1'b0; ph <= 0; end
          end
          default: ;
        endcase
        if (job_live) begin
          chk("div_a_stable", bus.div_a, qa);
          chk("div_b_stable", bus.div_b, qb);
        end
      end
      if (prev_hold && bus.out_valid) begin
        chk("hold_out_q", bus.out_q, prev_q);
        chk("hold_out_status", bus.out_status, prev_st);
      end
      prev_hold <= bus.out_valid && !bus.out_ready;
      prev_q    <= bus.out_q;
      prev_st   <= bus.out_status;
      if (bus.out_valid && bus.out_ready) begin
        chk("resp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("resp_out_q", bus.out_q, exp_q[0].q);
          chk("resp_out_status", bus.out_status, exp_q[0].st);
          exp_q.delete(0);
        end
        n_resp   <= n_resp + 1;
        job_live <= 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_job(input int a, input int b, input int mode, input int lat,
                          input int extra, input int bound, output bit ok);
    ok = 0;
    p_mode = mode; p_lat = lat; p_extra = extra;
    bus.in_dividend = DW'(a);
    bus.in_divisor  = DW'(b);
    bus.in_valid    = 1'b1;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target, input int bound);
    for (int i = 0; i < bound && n_resp < target; i++) @(negedge clk);
    chk("resp_count", n_resp, target);
    step(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_div_start"}, bus.div_start, 0);
    chk({tag, "_div_a"}, bus.div_a, 0);
    chk({tag, "_div_b"}, bus.div_b, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_q"}, bus.out_q, 0);
    chk({tag, "_out_status"}, bus.out_status, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int s, r, a, b, m, lat;
    bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0; bus.out_ready = 1'b0;

    step(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step(1);
    chk("in_ready_after_reset", bus.in_ready, 1);

    // Normal job, q=14 after 12 cycles, busy held one cycle past valid.
    bus.out_ready = 1'b1;
    s = n_start; r = n_resp;
    push_job(100, 7, M_OK, 12, 1, 40, ok);
    chk("push_100_7", ok, 1);
    wait_resp(r + 1, 200);
    chk("one_start_100_7", n_start - s, 1);

    // Divide by zero: no divider start, result one cycle after the pop.
    bus.out_ready = 1'b0;
    s = n_start; r = n_resp;
    push_job(55, 0, M_OK, 3, 0, 40, ok);
    @(negedge clk);
    chk("dvz_not_early", bus.out_valid, 0);
    @(negedge clk);
    chk("dvz_latency", bus.out_valid, 1);
    chk("dvz_q", bus.out_q, 0);
    chk("dvz_status", bus.out_status, 1);
    step(1);
    bus.out_ready = 1'b1;
    wait_resp(r + 1, 50);
    chk("dvz_no_start", n_start - s, 0);

    // Overflow: busy falls without a result.
    r = n_resp;
    push_job(1023, 1, M_OVF, 6, 0, 40, ok);
    wait_resp(r + 1, 100);

    // Hang: busy never rises; the next queued job must still be issued.
    bus.out_ready = 1'b0;
    s = n_start; r = n_resp;
    push_job(50, 5, M_HANG, 3, 0, 40, ok);
    push_job(40, 8, M_OK, 4, 0, 40, ok);
    for (int i = 0; i < 300 && !bus.out_valid; i++) @(negedge clk);
    chk("tmo_latency_in_range",
        (cyc - last_start_cyc >= TMO + 1) && (cyc - last_start_cyc <= TMO + 3), 1);
    chk("tmo_status", bus.out_status, 3);
    chk("tmo_q", bus.out_q, 0);
    step(1);
    bus.out_ready = 1'b1;
    wait_resp(r + 2, 300);
    chk("tmo_next_issued", n_start - s, 2);

    // Backpressure: one job in service plus a full FIFO, then a stalled offer.
    bus.out_ready = 1'b0;
    r = n_resp;
    push_job(20, 4, M_OK, 5, 1, 40, ok); chk("bp_accept_0", ok, 1);
    push_job(9, 3, M_OK, 3, 0, 40, ok);  chk("bp_accept_1", ok, 1);
    push_job(8, 0, M_OK, 3, 0, 40, ok);  chk("bp_accept_2", ok, 1);
    push_job(7, 7, M_OK, 8, 2, 40, ok);  chk("bp_accept_3", ok, 1);
    push_job(30, 6, M_OK, 4, 0, 40, ok); chk("bp_accept_4", ok, 1);
    push_job(11, 2, M_OK, 3, 0, 8, ok);  chk("bp_stall", ok, 0);
    chk("bp_in_ready_low", bus.in_ready, 0);
    step(10);
    chk("bp_first_valid", bus.out_valid, 1);
    chk("bp_first_q", bus.out_q, 5);
    chk("bp_first_status", bus.out_status, 0);
    for (int i = 0; i < 400 && n_resp < r + 5; i++) begin
      bus.out_ready = i[0];
      step(1);
    end
    bus.out_ready = 1'b1;
    push_job(11, 2, M_OK, 3, 0, 40, ok); chk("bp_accept_late", ok, 1);
    wait_resp(r + 6, 100);

    // Reset during RUN with two jobs queued.
    bus.out_ready = 1'b0;
    push_job(200, 3, M_OK, 30, 0, 40, ok);
    push_job(50, 5, M_OK, 3, 0, 40, ok);
    push_job(60, 6, M_OK, 3, 0, 40, ok);
    step(8);
    s = n_start; r = n_resp;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    chk("midrun_in_ready", bus.in_ready, 1);
    step(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step(20);
    chk("rst_no_resp", n_resp - r, 0);
    chk("rst_no_start", n_start - s, 0);
    chk("rst_out_valid", bus.out_valid, 0);

    // Randomized jobs under random backpressure.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          a = $urandom_range(0, 1023);
          b = $urandom_range(0, 9);
          b = (b == 0) ? 0 : (b < 4) ? $urandom_range(1, 15) : $urandom_range(1, 1023);
          m = $urandom_range(0, 99);
          m = (m < 80) ? M_OK : (m < 95) ? M_OVF : M_HANG;
          lat = $urandom_range(3, 20);
          push_job(a, b, m, lat, $urandom_range(0, 3), 600, ok);
          chk("rnd_accept", ok, 1);
          step($urandom_range(0, 2));
        end
        rnd_done = 1;
      end
      begin
        for (int k = 0; k < 20000 && !(rnd_done && exp_q.size() == 0); k++) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    step(5);
    chk("rnd_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
